// File: rtl/de_hazard_ctrl_pkg.sv
// Shared parameters, state encoding and sizing helpers for the decode-stage
// hazard/flush controller.
package de_hazard_ctrl_pkg;

    localparam int REGS         = 32;
    localparam int REGNOBITS    = 5;
    localparam int CNTBITS      = 2;
    localparam int FLUSH_CYCLES = 2;
    localparam int PENDBITS     = 7;

    localparam logic [CNTBITS-1:0] CNT_MAX = '1;

    // Flush down-counter only needs to hold FLUSH_CYCLES-1.
    localparam int FCBITS = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCBITS-1:0] FLUSH_LOAD = FCBITS'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/de_hazard_ctrl_if.sv
// Decode/WB/AGEX signal bundle between DE_STAGE (master) and the hazard
// controller (slave).
interface de_hazard_ctrl_if;
    import de_hazard_ctrl_pkg::*;

    logic                 de_valid;
    logic                 de_use_rs1;
    logic                 de_use_rs2;
    logic [REGNOBITS-1:0] de_rs1;
    logic [REGNOBITS-1:0] de_rs2;
    logic                 de_wr_reg;
    logic [REGNOBITS-1:0] de_rd;
    logic                 de_serialize;
    logic                 wb_wr_reg;
    logic [REGNOBITS-1:0] wb_rd;
    logic                 br_mispred;

    logic                 stall_de;
    logic                 flush_fe;
    logic                 issue;
    logic                 busy;
    logic [PENDBITS-1:0]  pending_count;
    logic                 err_underflow;

    modport master (
        output de_valid, de_use_rs1, de_use_rs2, de_rs1, de_rs2,
               de_wr_reg, de_rd, de_serialize, wb_wr_reg, wb_rd, br_mispred,
        input  stall_de, flush_fe, issue, busy, pending_count, err_underflow
    );

    modport slave (
        input  de_valid, de_use_rs1, de_use_rs2, de_rs1, de_rs2,
               de_wr_reg, de_rd, de_serialize, wb_wr_reg, wb_rd, br_mispred,
        output stall_de, flush_fe, issue, busy, pending_count, err_underflow
    );

endinterface

// File: rtl/de_hazard_ctrl_reg_use_counter.sv
// Saturating up/down count of outstanding writes to one architectural register.
module reg_use_counter
    import de_hazard_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [CNTBITS-1:0] cnt,
    output logic               zero,
    output logic               max,
    output logic               underflow
);

    assign zero      = (cnt == '0);
    assign max       = (cnt == CNT_MAX);
    assign underflow = dec & ~inc & zero;

    // Simultaneous inc and dec cancel; both ends hold rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && !dec && !max) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/de_hazard_ctrl.sv
// Decode-stage scoreboard: RAW/saturation/serialize stalls and a fixed-length
// front-end flush after an AGEX mispredict.
module de_hazard_ctrl
    import de_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    de_hazard_ctrl_if.slave  bus
);

    logic [CNTBITS-1:0] cnt      [REGS];
    logic [REGS-1:0]    is_zero;
    logic [REGS-1:0]    is_max;
    logic [REGS-1:0]    uflow;
    logic [REGS-1:0]    inc_vec;
    logic [REGS-1:0]    dec_vec;

    state_e             state_q, state_d;
    logic [FCBITS-1:0]  fcnt_q, fcnt_d;
    logic [PENDBITS-1:0] pending;
    logic               err_q;

    logic haz_rs1, haz_rs2, sat, wb_retire, busy;
    logic issue, stall, flush;

    // x0 is hardwired: never busy, never saturated, never underflows.
    assign cnt[0]     = '0;
    assign is_zero[0] = 1'b1;
    assign is_max[0]  = 1'b0;
    assign uflow[0]   = 1'b0;
    assign inc_vec[0] = 1'b0;
    assign dec_vec[0] = 1'b0;

    for (genvar i = 1; i < REGS; i++) begin : g_cnt
        assign inc_vec[i] = issue & bus.de_wr_reg & (bus.de_rd == REGNOBITS'(i));
        assign dec_vec[i] = bus.wb_wr_reg & (bus.wb_rd == REGNOBITS'(i));

        reg_use_counter u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_vec[i]),
            .dec       (dec_vec[i]),
            .cnt       (cnt[i]),
            .zero      (is_zero[i]),
            .max       (is_max[i]),
            .underflow (uflow[i])
        );
    end

    always_comb begin
        pending = '0;
        for (int i = 1; i < REGS; i++) begin
            pending = pending + PENDBITS'(cnt[i]);
        end
    end

    assign busy = (pending != '0);

    // A WB landing on a source whose last outstanding write it is resolves the
    // hazard: the register file writes on negedge, ahead of the next posedge.
    assign haz_rs1 = bus.de_use_rs1 & (bus.de_rs1 != '0) & ~is_zero[bus.de_rs1]
                   & ~(bus.wb_wr_reg & (bus.wb_rd == bus.de_rs1) & (cnt[bus.de_rs1] == CNTBITS'(1)));
    assign haz_rs2 = bus.de_use_rs2 & (bus.de_rs2 != '0) & ~is_zero[bus.de_rs2]
                   & ~(bus.wb_wr_reg & (bus.wb_rd == bus.de_rs2) & (cnt[bus.de_rs2] == CNTBITS'(1)));

    assign sat = bus.de_wr_reg & (bus.de_rd != '0) & is_max[bus.de_rd]
               & ~(bus.wb_wr_reg & (bus.wb_rd == bus.de_rd));

    assign wb_retire = bus.wb_wr_reg & (bus.wb_rd != '0) & ~is_zero[bus.wb_rd];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (|uflow) begin
                err_q <= 1'b1;
            end
        end
    end

    // A mispredict overrides whatever the current state would do and restarts the flush.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        issue   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;

        case (state_q)
            RUN: begin
                issue = bus.de_valid & ~haz_rs1 & ~haz_rs2 & ~sat
                      & ~(bus.de_serialize & busy);
                stall = bus.de_valid & ~issue;
                if (bus.de_valid && bus.de_serialize && busy) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (pending == '0 || (pending == PENDBITS'(1) && wb_retire)) begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                stall = 1'b1;
                flush = 1'b1;
                if (fcnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (bus.br_mispred) begin
            issue   = 1'b0;
            stall   = 1'b1;
            flush   = 1'b1;
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
        end
    end

    assign bus.issue         = issue;
    assign bus.stall_de      = stall;
    assign bus.flush_fe      = flush;
    assign bus.busy          = busy;
    assign bus.pending_count = pending;
    assign bus.err_underflow = err_q;

endmodule

// File: doc/de_hazard_ctrl.md
# de_hazard_ctrl

Scoreboard and stall/flush controller for the decode stage. Tracks in-flight destination registers with per-register outstanding-write counters, stalls decode on RAW hazards, counter saturation and serializing (CSR) instructions, and runs a fixed-length front-end flush after an AGEX branch mispredict. Sits beside DE_STAGE: takes decode-side operand/destination info, the AGEX mispredict and the WB write-back, and drives the stall that DE_STAGE forwards to FE.

## Interface
- REGS, 32: architectural registers; x0 is never tracked.
- REGNOBITS, 5: register index width.
- CNTBITS, 2: per-register counter width; max outstanding writes per register = 2^CNTBITS-1 (3).
- FLUSH_CYCLES, 2: cycles of flush after a mispredict (>=1).
- PENDBITS, 7: width of pending_count (holds REGS-1 times max count).

- clk  in  1  pipeline clock, posedge
- reset  in  1  synchronous, active-high
- de_valid  in  1  decode holds a valid instruction
- de_use_rs1, de_use_rs2  in  1 each  instruction reads rs1/rs2
- de_rs1, de_rs2  in  REGNOBITS each  source indices
- de_wr_reg  in  1  instruction writes rd
- de_rd  in  REGNOBITS  destination index
- de_serialize  in  1  instruction must wait until no writes are outstanding (CSRR/CSRW)
- wb_wr_reg  in  1  WB writes a register this cycle
- wb_rd  in  REGNOBITS  WB destination
- br_mispred  in  1  AGEX branch mispredict, one-cycle pulse
- stall_de  out  1  decode must hold and insert bubble into DE latch
- flush_fe  out  1  squash FE/DE contents
- issue  out  1  decode instruction accepted this cycle
- busy  out  1  pending_count != 0
- pending_count  out  PENDBITS  total outstanding tracked writes
- err_underflow  out  1  sticky: WB retired a register with zero count

## Operation
- States: RUN, FLUSH, DRAIN.
- Hazard (combinational): rsN hazard = de_use_rsN & rsN!=0 & cnt[rsN]!=0, except cleared when wb_wr_reg & wb_rd==rsN & cnt[rsN]==1 (register file writes on negedge; value is valid before next posedge).
- Saturation stall: de_wr_reg & de_rd!=0 & cnt[de_rd]==max & not (same-cycle WB to de_rd).
- RUN: issue = de_valid & !hazard & !saturation & !(de_serialize & busy) & !br_mispred. de_serialize & busy & de_valid & !br_mispred -> DRAIN. stall_de = de_valid & !issue.
- DRAIN: stall_de=1, issue=0; when pending_count==0 or (==1 and a same-cycle WB retires it) -> RUN next cycle.
- FLUSH: stall_de=1, flush_fe=1, issue=0; down-counter loaded FLUSH_CYCLES-1 on entry; at 0 -> RUN.
- br_mispred in any state: flush_fe=1, stall_de=1 that cycle, next state FLUSH with counter reloaded (back-to-back mispredicts extend the flush).
- Counters: on issue & de_wr_reg & de_rd!=0 increment cnt[de_rd]; on wb_wr_reg & wb_rd!=0 decrement cnt[wb_rd]; both to same register same cycle -> unchanged. Decrement at 0: counter stays 0, err_underflow set until reset. Writes to x0 ignored both sides.
- pending_count = sum of counters, updated in the same edge.
- Mispredict never clears counters (all issued instructions are older than the branch).

## Timing
- stall_de, flush_fe, issue: combinational from state and current inputs, same cycle.
- Counters, state, pending_count, busy, err_underflow: registered, update on posedge clk.
- Mispredict at cycle t: flush_fe high t..t+FLUSH_CYCLES; first issue possible at t+FLUSH_CYCLES+1.
- Reset: next edge -> state RUN, all counters 0, pending_count 0, busy 0, err_underflow 0; with de_valid=0 and br_mispred=0, stall_de=0, flush_fe=0, issue=0. Reset dominates all same-cycle events including br_mispred and WB.

## Structure
- Shared package/define.vh: state encoding (RUN/FLUSH/DRAIN localparams), REGNOBITS, REGS reused from existing defines.
- Sub-module reg_use_counter: one saturating up/down counter (inc, dec, cnt, zero, max, underflow), instantiated REGS-1 times via generate.

## Test plan
- ADD x5 issues, then ADD x6,x5,x1 next cycle -> stall_de=1 until WB x5; same-cycle WB x5 -> issue=1 that cycle, cnt[x5]=0 after edge.
- Four back-to-back writes to x7 with no WB -> first three issue, fourth stalls (cnt=3); WB x7 in same cycle as fourth -> fourth issues, cnt stays 3.
- CSRW with pending_count=2 -> DRAIN, stall_de=1; two WBs -> RUN, CSRW issues one cycle after pending_count reaches 0.
- br_mispred at t=10, FLUSH_CYCLES=2 -> flush_fe=1 at t=10,11,12; second mispred at t=11 -> flush_fe through t=13.
- WB to x9 with cnt 0 -> err_underflow=1 stays high, counters unchanged; reset clears it.
- Reset asserted mid-FLUSH with pending_count=4 -> next cycle RUN, pending_count=0, busy=0, stall_de=0 with de_valid=0.
